tamagotchi_needs_engine: RTL

//  Parametrised successor of the tamagotchi FSM. Tracks NUM_NEEDS need levels (salud, energia,

---
 rtl/tamagotchi_needs_engine.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tamagotchi_needs_engine.sv
// Need-level engine: per-need decay, long-press soft reset / test toggle,
// NORMAL/TEST/CRITICAL/DEAD mode FSM and a registered 7-seg display path.
module tamagotchi_needs_engine #(
  parameter int unsigned NUM_NEEDS   = 4,
  parameter int unsigned LVL_W       = 4,
  parameter int unsigned LVL_MAX     = 5,
  parameter int unsigned CRIT_LVL    = 1,
  parameter int unsigned DECAY_TICKS = 10,
  parameter int unsigned DEAD_TICKS  = 5,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned DISP_TICKS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [NUM_NEEDS-1:0]          btn_need,
  input  logic                          btn_reset,
  input  logic                          btn_test,
  output logic [NUM_NEEDS*LVL_W-1:0]    levels,
  output logic [1:0]                    mode,
  output logic [$clog2(NUM_NEEDS)-1:0]  display_out,
  output logic [6:0]                    seg_display,
  output logic                          alarm
);

  localparam int unsigned IDX_W  = $clog2(NUM_NEEDS);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DEC_W  = $clog2(DECAY_TICKS + 1);
  localparam int unsigned DEAD_W = $clog2(DEAD_TICKS + 1);
  localparam int unsigned ROT_W  = $clog2(DISP_TICKS + 1);
  localparam int unsigned SUM_W  = LVL_W + 1;
  localparam logic [6:0]  SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_TEST   = 2'd1,
    MODE_CRIT   = 2'd2,
    MODE_DEAD   = 2'd3
  } mode_e;

  // Decimal digit to gfedcba segments; anything above 9 is blank.
  function automatic logic [6:0] seg_of(input logic [LVL_W-1:0] v);
    logic [6:0] s;
    case (v)
      LVL_W'(0): s = 7'b0111111;
      LVL_W'(1): s = 7'b0000110;
      LVL_W'(2): s = 7'b1011011;
      LVL_W'(3): s = 7'b1001111;
      LVL_W'(4): s = 7'b1100110;
      LVL_W'(5): s = 7'b1101101;
      LVL_W'(6): s = 7'b1111101;
      LVL_W'(7): s = 7'b0000111;
      LVL_W'(8): s = 7'b1111111;
      LVL_W'(9): s = 7'b1101111;
      default:   s = 7'b0000000;
    endcase
    return s;
  endfunction

  mode_e              mode_q,     mode_d;
  logic [LVL_W-1:0]   lvl_q [NUM_NEEDS];
  logic [LVL_W-1:0]   lvl_d [NUM_NEEDS];
  logic [HOLD_W-1:0]  hold_rst_q, hold_rst_d;
  logic [HOLD_W-1:0]  hold_tst_q, hold_tst_d;
  logic [DEC_W-1:0]   dec_cnt_q,  dec_cnt_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [ROT_W-1:0]   rot_cnt_q,  rot_cnt_d;
  logic [IDX_W-1:0]   disp_q,     disp_d;
  logic [6:0]         seg_q,      seg_d;
  logic               alarm_q,    alarm_d;

  logic               rst_fire, tst_fire, live, run, dec_step;
  logic               any_zero, any_crit;
  logic [SUM_W-1:0]   sum;
  logic [IDX_W-1:0]   low_idx;

  // Next-state for the mode FSM, levels, counters and display outputs.
  always_comb begin
    mode_d     = mode_q;
    hold_rst_d = '0;
    hold_tst_d = '0;
    dec_cnt_d  = dec_cnt_q;
    ptr_d      = ptr_q;
    dead_cnt_d = dead_cnt_q;
    rot_cnt_d  = rot_cnt_q;
    disp_d     = disp_q;
    dec_step   = 1'b0;
    any_zero   = 1'b0;
    any_crit   = 1'b0;
    sum        = '0;
    low_idx    = '0;
    for (int i = 0; i < int'(NUM_NEEDS); i++) lvl_d[i] = lvl_q[i];

    // Long-press detection: fire only on the cycle the count reaches the hold length.
    rst_fire = btn_reset && (hold_rst_q == HOLD_W'(HOLD_CYCLES - 1));
    tst_fire = btn_test  && (hold_tst_q == HOLD_W'(HOLD_CYCLES - 1));
    if (btn_reset) hold_rst_d = (hold_rst_q == HOLD_W'(HOLD_CYCLES)) ? hold_rst_q
                                                                     : hold_rst_q + HOLD_W'(1);
    if (btn_test)  hold_tst_d = (hold_tst_q == HOLD_W'(HOLD_CYCLES)) ? hold_tst_q
                                                                     : hold_tst_q + HOLD_W'(1);

    live = (mode_q != MODE_DEAD);
    run  = (mode_q == MODE_NORMAL) || (mode_q == MODE_CRIT);

    // Round-robin decay, frozen in TEST and DEAD.
    if (run && tick) begin
      if (dec_cnt_q == DEC_W'(DECAY_TICKS - 1)) begin
        dec_cnt_d = '0;
        dec_step  = 1'b1;
        ptr_d     = (ptr_q == IDX_W'(NUM_NEEDS - 1)) ? '0 : ptr_q + IDX_W'(1);
      end else begin
        dec_cnt_d = dec_cnt_q + DEC_W'(1);
      end
    end

    // Presses and decay are summed before clamping, so press+decay nets to zero.
    if (live) begin
      for (int i = 0; i < int'(NUM_NEEDS); i++) begin
        sum = {1'b0, lvl_q[i]};
        if (run && btn_need[i]) sum = sum + SUM_W'(1);
        if (((mode_q == MODE_TEST) && btn_need[i]) || (dec_step && (ptr_q == IDX_W'(i))))
          sum = (sum == '0) ? '0 : sum - SUM_W'(1);
        if (sum > SUM_W'(LVL_MAX)) sum = SUM_W'(LVL_MAX);
        lvl_d[i] = sum[LVL_W-1:0];
      end
    end

    for (int i = 0; i < int'(NUM_NEEDS); i++) begin
      if (lvl_d[i] == '0) any_zero = 1'b1;
      if (lvl_d[i] <= LVL_W'(CRIT_LVL)) any_crit = 1'b1;
    end

    if (!any_zero) dead_cnt_d = '0;
    else if (tick && (dead_cnt_q != DEAD_W'(DEAD_TICKS))) dead_cnt_d = dead_cnt_q + DEAD_W'(1);

    // Mode transitions; TEST is sticky until toggled, DEAD only leaves via soft reset.
    case (mode_q)
      MODE_DEAD: mode_d = MODE_DEAD;
      MODE_TEST: if (tst_fire) mode_d = any_crit ? MODE_CRIT : MODE_NORMAL;
      default:   mode_d = tst_fire ? MODE_TEST : (any_crit ? MODE_CRIT : MODE_NORMAL);
    endcase
    if (live && (dead_cnt_d == DEAD_W'(DEAD_TICKS))) mode_d = MODE_DEAD;

    // Display selection: lowest pressed need wins, otherwise timed rotation.
    for (int i = int'(NUM_NEEDS) - 1; i >= 0; i--) if (btn_need[i]) low_idx = IDX_W'(i);
    if (live && (|btn_need)) begin
      disp_d    = low_idx;
      rot_cnt_d = '0;
    end else if (tick) begin
      if (rot_cnt_q == ROT_W'(DISP_TICKS - 1)) begin
        rot_cnt_d = '0;
        disp_d    = (disp_q == IDX_W'(NUM_NEEDS - 1)) ? '0 : disp_q + IDX_W'(1);
      end else begin
        rot_cnt_d = rot_cnt_q + ROT_W'(1);
      end
    end

    // Soft reset overrides every other action in the same cycle.
    if (rst_fire) begin
      for (int i = 0; i < int'(NUM_NEEDS); i++) lvl_d[i] = LVL_W'(LVL_MAX);
      mode_d     = MODE_NORMAL;
      dec_cnt_d  = '0;
      ptr_d      = '0;
      dead_cnt_d = '0;
      rot_cnt_d  = '0;
      disp_d     = '0;
    end

    seg_d   = (mode_d == MODE_DEAD) ? SEG_DASH : seg_of(lvl_d[disp_d]);
    alarm_d = (mode_d == MODE_CRIT) || (mode_d == MODE_DEAD);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_NORMAL;
      for (int i = 0; i < int'(NUM_NEEDS); i++) lvl_q[i] <= LVL_W'(LVL_MAX);
      hold_rst_q <= '0;
      hold_tst_q <= '0;
      dec_cnt_q  <= '0;
      ptr_q      <= '0;
      dead_cnt_q <= '0;
      rot_cnt_q  <= '0;
      disp_q     <= '0;
      seg_q      <= seg_of(LVL_W'(LVL_MAX));
      alarm_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      for (int i = 0; i < int'(NUM_NEEDS); i++) lvl_q[i] <= lvl_d[i];
      hold_rst_q <= hold_rst_d;
      hold_tst_q <= hold_tst_d;
      dec_cnt_q  <= dec_cnt_d;
      ptr_q      <= ptr_d;
      dead_cnt_q <= dead_cnt_d;
      rot_cnt_q  <= rot_cnt_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      alarm_q    <= alarm_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_NEEDS); g++) begin : g_lvl_out
    assign levels[g*LVL_W +: LVL_W] = lvl_q[g];
  end

  assign mode        = mode_q;
  assign display_out = disp_q;
  assign seg_display = seg_q;
  assign alarm       = alarm_q;

endmodule
